// File: rtl/conv3x3_window_engine_if.sv
// ---------------------------------------------------------------------------
// conv3x3_window_engine_if
// Bundles the control, kernel-load, image-read and result-stream signals of
// conv3x3_window_engine.
//   master : the engine (drives mem_rd/mem_addr, the result stream, busy/done)
//   slave  : the environment (drives start, kernel writes, mem_dout)
// Signals:
//   start            begin one image pass (sampled only while idle)
//   k_wr/k_idx/k_data kernel coefficient write (tap = r*3+c)
//   mem_rd/mem_addr  image read request; mem_dout returns one cycle later
//   out_valid/out_data/out_row/out_col  result stream
//   busy/done        pass status
// ---------------------------------------------------------------------------
interface conv3x3_window_engine_if #(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int RW = 3,
  parameter int CW = 3
);
  logic                 start;
  logic                 k_wr;
  logic [3:0]           k_idx;
  logic signed [DW-1:0] k_data;
  logic                 mem_rd;
  logic [AW-1:0]        mem_addr;
  logic signed [DW-1:0] mem_dout;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [RW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, k_wr, k_idx, k_data, mem_dout,
    output mem_rd, mem_addr, out_valid, out_data, out_row, out_col, busy, done
  );

  modport slave (
    output start, k_wr, k_idx, k_data, mem_dout,
    input  mem_rd, mem_addr, out_valid, out_data, out_row, out_col, busy, done
  );
endinterface

// File: rtl/conv3x3_window_engine.sv
// ---------------------------------------------------------------------------
// conv3x3_window_engine
// Reads an IMG_H x IMG_W signed Q0.7 image through a 1-cycle-latency read
// port, convolves it with a locally stored signed Q0.7 3x3 kernel over the
// valid region, and streams (IMG_H-2)x(IMG_W-2) saturated Q0.7 results in
// raster order.
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          conv3x3_window_engine_if.master (see interface header)
//   o_dbg_state  current FSM state (IDLE=0, READ=1, DRAIN=2, EMIT=3, DONE=4)
//
// Stream protocol: there is no back-pressure. mem_rd is a fire-and-forget
// request whose data is taken from mem_dout exactly one cycle later;
// out_valid is a single-cycle strobe and out_data/out_row/out_col are only
// meaningful while it is high (they hold their last value otherwise).
//
// Per result (base cycle B): READ B..B+8 issues the 9 tap reads, DRAIN B+9
// absorbs the last returning pixel, EMIT B+10 presents the result.
// ---------------------------------------------------------------------------
module conv3x3_window_engine #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 20,
  parameter int FRAC  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv3x3_window_engine_if.master bus,
  output logic [2:0]           o_dbg_state
);
  localparam int AW = $clog2(IMG_W * IMG_H);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 3);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (DW - 1)));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_tap;
  logic [3:0]              r_tap_d;
  logic                    r_rd_d;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic signed [DW-1:0]    r_kern [0:8];
  logic signed [ACC_W-1:0] r_acc;
  logic [AW-1:0]           r_addr_hold;
  logic signed [DW-1:0]    r_out_data;
  logic [RW-1:0]           r_out_row;
  logic [CW-1:0]           r_out_col;

  logic                    w_mem_rd;
  logic                    w_out_valid;
  logic                    w_last;
  logic [1:0]              w_tr;
  logic [1:0]              w_tc;
  logic [AW-1:0]           w_addr;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [DW-1:0]    w_sat;

  assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);

  // Next-state and decoded status outputs.
  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_READ;
      S_READ: begin
        w_mem_rd = 1'b1;
        if (r_tap == 4'd8) w_next_state = S_DRAIN;
      end
      S_DRAIN: w_next_state = S_EMIT;
      S_EMIT: begin
        w_out_valid  = 1'b1;
        w_next_state = w_last ? S_DONE : S_READ;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Tap index -> window offset (row = t/3, col = t%3).
  always_comb begin
    w_tr   = (r_tap >= 4'd6) ? 2'd2 : ((r_tap >= 4'd3) ? 2'd1 : 2'd0);
    w_tc   = 2'(r_tap - (4'(w_tr) * 4'd3));
    w_addr = (AW'(r_row) + AW'(w_tr)) * AW'(IMG_W) + AW'(r_col) + AW'(w_tc);
  end

  // Full-width signed product, sign-extended into the accumulator.
  assign w_prod     = bus.mem_dout * r_kern[r_tap_d];
  assign w_prod_ext = {{(ACC_W - 2*DW){w_prod[2*DW-1]}}, w_prod};

  // Arithmetic shift floors toward -inf, then clamp to the output range.
  always_comb begin
    w_shift = r_acc >>> FRAC;
    if (w_shift > SAT_HI)      w_sat = DW'(SAT_HI);
    else if (w_shift < SAT_LO) w_sat = DW'(SAT_LO);
    else                       w_sat = DW'(w_shift);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_tap_d     <= '0;
      r_rd_d      <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_acc       <= '0;
      r_addr_hold <= '0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      for (int i = 0; i < 9; i++) r_kern[i] <= '0;
    end else begin
      r_state <= w_next_state;
      r_rd_d  <= w_mem_rd;
      r_tap_d <= r_tap;
      case (r_state)
        S_IDLE: begin
          if (bus.k_wr && (bus.k_idx <= 4'd8)) r_kern[bus.k_idx] <= bus.k_data;
          r_tap <= '0;
          r_row <= '0;
          r_col <= '0;
        end
        S_READ: r_tap <= (r_tap == 4'd8) ? 4'd0 : r_tap + 4'd1;
        S_EMIT: begin
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_mem_rd) r_addr_hold <= w_addr;
      if (w_out_valid) begin
        r_out_data <= w_sat;
        r_out_row  <= r_row;
        r_out_col  <= r_col;
      end
      // Clear on the first read of a window; the previous window's last
      // pixel was already absorbed in DRAIN, so the two never collide.
      if (w_mem_rd && (r_tap == 4'd0)) r_acc <= '0;
      else if (r_rd_d)                 r_acc <= r_acc + w_prod_ext;
    end
  end

  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_addr  = w_mem_rd ? w_addr : r_addr_hold;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_sat : r_out_data;
  assign bus.out_row   = w_out_valid ? r_row : r_out_row;
  assign bus.out_col   = w_out_valid ? r_col : r_out_col;
  assign bus.busy      = (r_state == S_READ) || (r_state == S_DRAIN) || (r_state == S_EMIT);
  assign bus.done      = (r_state == S_DONE);
  assign o_dbg_state   = r_state;
endmodule
